cpu_stack: RTL and testbench
============================

# cpu_stack

Parametrised hardware stack for the CPU: register backup in assembly routines and interrupt context save. It is the successor to the fixed 32x128 stack. Width and depth are configurable, and it adds occupancy flags, a level count, protected overflow/underflow with sticky error interrupts, and a defined same-cycle push+pop (replace-top). It sits beside the register file and takes the same pipeline `clear`/`hold` controls as the old stack.

## Interface
- `WIDTH`, 32: entry width in bits.
- `DEPTH`, 128: number of entries. Must be a power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`: pointer width. Derived; do not override.
- `clk`  in  1  clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset. Wins over every other input.
- `d`  in  `WIDTH`  push data.
- `push`  in  1  push request.
- `pop`  in  1  pop request.
- `clear`  in  1  pipeline flush. Qualifies `pop` only.
- `hold`  in  1  pipeline stall. Qualifies `pop` only. `clear` has priority over `hold`.
- `irq_ack`  in  1  clears both sticky error flags.
- `q`  out  `WIDTH`  registered pop result.
- `count`  out  `AW+1`  current number of entries, 0..`DEPTH`.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `ovf`  out  1  sticky: a push was rejected while full.
- `unf`  out  1  sticky: a pop was rejected while empty.
- `irq`  out  1  `ovf | unf`.

## Operation
- State: `count` register (`AW+1` bits), `DEPTH x WIDTH` storage array (not reset, no initial contents required), `q`, `ovf`, `unf`. Top of stack is at index `count-1`.
- **Effective pop:** `ep = pop & ~clear & ~hold`.
- `pop & clear` → `q <= 0`. Count and array are unchanged.
- `pop & hold & ~clear` → `q` holds. Count and array are unchanged.
- `push` is never qualified by `clear`/`hold`.
- Per-cycle behaviour when not in reset, with `push` and `ep` (first matching case applies):
  - `push & ~ep & ~full`: `mem[count] <= d`, `count+1`.
  - `push & ~ep & full`: write dropped, count unchanged, `ovf <= 1`.
  - `~push & ep & ~empty`: `q <= mem[count-1]`, `count-1`.
  - `~push & ep & empty`: `q <= 0`, count unchanged, `unf <= 1`.
  - `push & ep & ~empty`: replace-top. `q <= mem[count-1]` (old value), `mem[count-1] <= d`, count unchanged. No error. Legal when full.
  - `push & ep & empty`: pass-through. `q <= d`, nothing stored, count stays 0. No error.
- Pointer arithmetic never wraps. Guards prevent `count-1` from being evaluated at 0, and prevent any index ≥ `DEPTH`.
- `irq_ack` clears `ovf`/`unf`. A new error in the same cycle as `irq_ack` wins: the flag is set.
- Reset: `count=0`, `q=0`, `ovf=0`, `unf=0`, so `empty=1`, `full=0`, `irq=0`. Array contents are don't-care. Reset mid-sequence discards all entries, and any push/pop in the reset cycle is ignored.

## Timing
- One-cycle latency. `q` is valid the cycle after an effective pop and holds until the next effective pop, clear-pop or reset.
- `count`/`empty`/`full` update one cycle after the push/pop edge. `empty`/`full` are combinational decodes of the registered `count`.
- Push-then-pop on consecutive cycles returns the just-pushed data, so no bypass is needed.
- `ovf`/`unf`/`irq` assert one cycle after the offending request.
- Storage is one write port plus one read port. It is inferable as a synchronous block RAM with read-before-write semantics for replace-top.
- Fully pipelined: one push or pop (or one pair) every cycle, no stalls generated.

## Test plan
1. `WIDTH=32`, `DEPTH=4`. Reset, then push `0x11`, `0x22`, `0x33` → `count=3`. Pop ×3 gives `q` = `0x33`, `0x22`, `0x11` on successive cycles, then `empty=1`.
2. Push `0xA0`..`0xA3` (full=1), then push `0xFF` → `count` stays 4, `ovf=1`, `irq=1`. Pop returns `0xA3`, and `0xFF` never appears. `irq_ack` → `ovf=0`.
3. From empty, pop → `q=0`, `unf=1`, `count=0`. Then simultaneous push `0x55` + pop → `q=0x55`, `count=0`, `unf` stays set until `irq_ack`.
4. Stack holds `0x1`, `0x2`. Push `0x9` + pop together → `q=0x2`, `count=2`. Next pop → `q=0x9`, then `q=0x1`.
5. Stack holds `0x7`, `q=0x3`. Pop with `hold` → `q=0x3`, `count=1`. Pop with `clear` (and `hold`) → `q=0`, `count=1`. Plain pop → `q=0x7`.
6. Push 3 entries, assert `reset` together with a push → `count=0`, `q=0`, flags 0. Subsequent pop → `unf=1`. Repeat 1–2 at `DEPTH=128`, `WIDTH=16`.

Source files
------------

// File: rtl/cpu_stack.sv
// cpu_stack: parametrised LIFO for register backup and interrupt context save.
// A same-cycle push+pop replaces the top entry; overflow/underflow are rejected and flagged.
module cpu_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic             hold,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] q,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf,
  output logic             irq
);

  localparam logic [AW:0]      FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]      ZERO_LVL  = {(AW+1){1'b0}};
  localparam logic [AW:0]      ONE_LVL   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]    ONE_IDX   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_WORD = {WIDTH{1'b0}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] q_r;
  logic             ovf_r;
  logic             unf_r;

  logic             ep_s;
  logic             is_empty_s;
  logic             is_full_s;
  logic [AW-1:0]    top_idx_s;
  logic [AW-1:0]    wr_idx_s;
  logic             do_push_s;
  logic             do_pop_s;
  logic             do_replace_s;
  logic             do_pass_s;
  logic             rej_push_s;
  logic             rej_pop_s;
  logic             mem_we_s;

  assign ep_s       = pop & ~clear & ~hold;
  assign is_empty_s = (count_r == ZERO_LVL);
  assign is_full_s  = (count_r == FULL_LVL);

  // Classify the cycle's request; exactly one action (or none) is selected.
  always_comb begin
    do_push_s    = 1'b0;
    do_pop_s     = 1'b0;
    do_replace_s = 1'b0;
    do_pass_s    = 1'b0;
    rej_push_s   = 1'b0;
    rej_pop_s    = 1'b0;
    case ({push, ep_s})
      2'b10: begin
        if (is_full_s) begin
          rej_push_s = 1'b1;
        end else begin
          do_push_s = 1'b1;
        end
      end
      2'b01: begin
        if (is_empty_s) begin
          rej_pop_s = 1'b1;
        end else begin
          do_pop_s = 1'b1;
        end
      end
      2'b11: begin
        if (is_empty_s) begin
          do_pass_s = 1'b1;
        end else begin
          do_replace_s = 1'b1;
        end
      end
      default: begin
        do_push_s = 1'b0;
      end
    endcase
  end

  // Index generation; the top index is only formed from a non-zero count so it never wraps.
  always_comb begin
    top_idx_s = {AW{1'b0}};
    wr_idx_s  = {AW{1'b0}};
    if (!is_empty_s) begin
      top_idx_s = count_r[AW-1:0] - ONE_IDX;
    end else begin
      top_idx_s = {AW{1'b0}};
    end
    if (do_push_s) begin
      wr_idx_s = count_r[AW-1:0];
    end else begin
      wr_idx_s = top_idx_s;
    end
  end

  assign mem_we_s = (do_push_s | do_replace_s) & ~reset;

  // Storage write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[wr_idx_s] <= d;
    end
  end

  // Registered read port; reads the pre-write top so replace-top returns the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= ZERO_WORD;
    end else if (pop && clear) begin
      q_r <= ZERO_WORD;
    end else if (do_pop_s || do_replace_s) begin
      q_r <= mem[top_idx_s];
    end else if (do_pass_s) begin
      q_r <= d;
    end else if (rej_pop_s) begin
      q_r <= ZERO_WORD;
    end else begin
      q_r <= q_r;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= ZERO_LVL;
    end else if (do_push_s) begin
      count_r <= count_r + ONE_LVL;
    end else if (do_pop_s) begin
      count_r <= count_r - ONE_LVL;
    end else begin
      count_r <= count_r;
    end
  end

  // Sticky error flags; a new error outranks an acknowledge in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (rej_push_s) begin
        ovf_r <= 1'b1;
      end else if (irq_ack) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      if (rej_pop_s) begin
        unf_r <= 1'b1;
      end else if (irq_ack) begin
        unf_r <= 1'b0;
      end else begin
        unf_r <= unf_r;
      end
    end
  end

  assign q     = q_r;
  assign count = count_r;
  assign empty = is_empty_s;
  assign full  = is_full_s;
  assign ovf   = ovf_r;
  assign unf   = unf_r;
  assign irq   = ovf_r | unf_r;

endmodule

// File: tb/tb_cpu_stack.sv
// Bench for cpu_stack: a DEPTH=4/WIDTH=32 and a DEPTH=128/WIDTH=16 instance share stimulus;
// a behavioural stack model queues expected outputs that are compared after each edge.
module tb_cpu_stack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, push, pop, clear, hold, irq_ack;
  logic [31:0] d;

  logic [31:0] q_a;
  logic [2:0]  count_a;
  logic        empty_a, full_a, ovf_a, unf_a, irq_a;
  logic [15:0] q_b;
  logic [7:0]  count_b;
  logic        empty_b, full_b, ovf_b, unf_b, irq_b;

  cpu_stack #(.WIDTH(32), .DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .d(d), .push(push), .pop(pop), .clear(clear),
    .hold(hold), .irq_ack(irq_ack), .q(q_a), .count(count_a), .empty(empty_a),
    .full(full_a), .ovf(ovf_a), .unf(unf_a), .irq(irq_a)
  );

  cpu_stack #(.WIDTH(16), .DEPTH(128)) dut_b (
    .clk(clk), .reset(reset), .d(d[15:0]), .push(push), .pop(pop), .clear(clear),
    .hold(hold), .irq_ack(irq_ack), .q(q_b), .count(count_b), .empty(empty_b),
    .full(full_b), .ovf(ovf_b), .unf(unf_b), .irq(irq_b)
  );

  typedef struct {
    logic [31:0] q;
    int          cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] m_mem [2][128];
  int          m_cnt [2];
  logic [31:0] m_q   [2];
  logic        m_ovf [2];
  logic        m_unf [2];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference stack for instance i, written from the behavioural description.
  task automatic model(input int i);
    int          dep;
    logic [31:0] mask, dd;
    logic        ep, eo, eu;
    exp_t        e;
    dep  = (i == 0) ? 4 : 128;
    mask = (i == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    dd   = d & mask;
    ep   = pop & ~clear & ~hold;
    eo   = 1'b0;
    eu   = 1'b0;
    if (reset) begin
      m_cnt[i] = 0; m_q[i] = 32'h0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
    end else begin
      if (pop && clear) m_q[i] = 32'h0;
      if (push && !ep) begin
        if (m_cnt[i] < dep) begin
          m_mem[i][m_cnt[i]] = dd;
          m_cnt[i] = m_cnt[i] + 1;
        end else eo = 1'b1;
      end else if (!push && ep) begin
        if (m_cnt[i] > 0) begin
          m_cnt[i] = m_cnt[i] - 1;
          m_q[i] = m_mem[i][m_cnt[i]];
        end else begin
          m_q[i] = 32'h0;
          eu = 1'b1;
        end
      end else if (push && ep) begin
        if (m_cnt[i] > 0) begin
          m_q[i] = m_mem[i][m_cnt[i]-1];
          m_mem[i][m_cnt[i]-1] = dd;
        end else m_q[i] = dd;
      end
      if (irq_ack) begin m_ovf[i] = 1'b0; m_unf[i] = 1'b0; end
      if (eo) m_ovf[i] = 1'b1;
      if (eu) m_unf[i] = 1'b1;
    end
    e.q = m_q[i]; e.cnt = m_cnt[i]; e.ovf = m_ovf[i]; e.unf = m_unf[i];
    sbq.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    e = sbq.pop_front();
    check("a_q", q_a, e.q);
    check("a_count", 32'(count_a), 32'(e.cnt));
    check("a_empty", 32'(empty_a), 32'(e.cnt == 0));
    check("a_full", 32'(full_a), 32'(e.cnt == 4));
    check("a_ovf", 32'(ovf_a), 32'(e.ovf));
    check("a_unf", 32'(unf_a), 32'(e.unf));
    check("a_irq", 32'(irq_a), 32'(e.ovf | e.unf));
    e = sbq.pop_front();
    check("b_q", 32'(q_b), e.q);
    check("b_count", 32'(count_b), 32'(e.cnt));
    check("b_empty", 32'(empty_b), 32'(e.cnt == 0));
    check("b_full", 32'(full_b), 32'(e.cnt == 128));
    check("b_ovf", 32'(ovf_b), 32'(e.ovf));
    check("b_unf", 32'(unf_b), 32'(e.unf));
    check("b_irq", 32'(irq_b), 32'(e.ovf | e.unf));
  endtask

  task automatic step(input logic p, input logic o, input logic c, input logic h,
                      input logic a, input logic r, input logic [31:0] din);
    push = p; pop = o; clear = c; hold = h; irq_ack = a; reset = r; d = din;
    model(0);
    model(1);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_push(input logic [31:0] v); step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v); endtask
  task automatic do_pop();                      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); endtask
  task automatic do_ack();                      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0); endtask
  task automatic do_reset();                    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0); endtask

  initial begin
    push = 1'b0; pop = 1'b0; clear = 1'b0; hold = 1'b0; irq_ack = 1'b0; reset = 1'b1; d = 32'h0;
    do_reset();
    do_reset();
    check("rst_count", 32'(count_a), 32'h0);
    check("rst_empty", 32'(empty_a), 32'h1);
    check("rst_irq", 32'(irq_a), 32'h0);

    // Basic LIFO order
    do_push(32'h11); do_push(32'h22); do_push(32'h33);
    check("t1_count", 32'(count_a), 32'h3);
    do_pop(); check("t1_pop0", q_a, 32'h33);
    do_pop(); check("t1_pop1", q_a, 32'h22);
    do_pop(); check("t1_pop2", q_a, 32'h11);
    check("t1_empty", 32'(empty_a), 32'h1);

    // Overflow on the 4-deep stack
    for (int i = 0; i < 4; i++) do_push(32'hA0 + 32'(i));
    check("t2_full", 32'(full_a), 32'h1);
    do_push(32'hFF);
    check("t2_count", 32'(count_a), 32'h4);
    check("t2_ovf", 32'(ovf_a), 32'h1);
    check("t2_irq", 32'(irq_a), 32'h1);
    do_pop(); check("t2_pop", q_a, 32'hA3);
    do_ack(); check("t2_ack", 32'(ovf_a), 32'h0);
    do_pop(); do_pop(); do_pop();
    check("t2_last", q_a, 32'hA0);

    // Underflow, then pass-through
    do_pop();
    check("t3_q", q_a, 32'h0);
    check("t3_unf", 32'(unf_a), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h55);
    check("t3_pass", q_a, 32'h55);
    check("t3_cnt", 32'(count_a), 32'h0);
    check("t3_unf_sticky", 32'(unf_a), 32'h1);
    do_ack(); check("t3_ack", 32'(unf_a), 32'h0);

    // Replace-top
    do_push(32'h1); do_push(32'h2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h9);
    check("t4_old", q_a, 32'h2);
    check("t4_cnt", 32'(count_a), 32'h2);
    do_pop(); check("t4_new", q_a, 32'h9);
    do_pop(); check("t4_bot", q_a, 32'h1);

    // hold / clear qualification
    do_push(32'h3); do_pop(); do_push(32'h7);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t5_hold_q", q_a, 32'h3);
    check("t5_hold_cnt", 32'(count_a), 32'h1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t5_clear_q", q_a, 32'h0);
    check("t5_clear_cnt", 32'(count_a), 32'h1);
    do_pop(); check("t5_pop", q_a, 32'h7);

    // Reset mid-sequence with a push in the reset cycle
    do_push(32'h4); do_push(32'h5); do_push(32'h6);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77);
    check("t6_cnt", 32'(count_a), 32'h0);
    check("t6_q", q_a, 32'h0);
    check("t6_irq", 32'(irq_a), 32'h0);
    do_pop(); check("t6_unf", 32'(unf_a), 32'h1);
    do_ack();

    // Deep instance: fill, overflow, LIFO readback
    do_reset();
    for (int i = 0; i < 130; i++) do_push(32'(i * 3 + 1));
    check("b_full_cnt", 32'(count_b), 32'd128);
    check("b_full_flag", 32'(full_b), 32'h1);
    check("b_ovf_flag", 32'(ovf_b), 32'h1);
    do_pop(); check("b_pop0", 32'(q_b), 32'd382);
    do_pop(); check("b_pop1", 32'(q_b), 32'd379);
    do_ack();

    // Random traffic, push-biased then pop-biased
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 200; n++) begin
        step(($urandom_range(99) < (ph == 0 ? 70 : 30)) ? 1'b1 : 1'b0,
             ($urandom_range(99) < (ph == 0 ? 30 : 70)) ? 1'b1 : 1'b0,
             ($urandom_range(99) < 8) ? 1'b1 : 1'b0,
             ($urandom_range(99) < 8) ? 1'b1 : 1'b0,
             ($urandom_range(99) < 10) ? 1'b1 : 1'b0,
             1'b0, $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
